// File: rtl/seq_bit_serializer_if.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer_if
// Word-in / bit-out stream bundle for seq_bit_serializer.
//   din       parallel word offered by the producer
//   din_valid producer has a word on din this cycle
//   din_ready serializer can take the word this cycle
//   x         serial bit toward the sequence detector
//   x_valid   x carries a data bit this cycle
//   last      x carries the final bit of a word this cycle
//   busy      a word is in the shifter or the holding register
// Handshake: a word moves on every rising clk edge where din_valid and
// din_ready are both high; din is ignored in every other cycle, and
// din_valid may stay high while din_ready is low without the word being taken.
// -----------------------------------------------------------------------------
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, last, busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
// Parallel-to-serial front end for the serial sequence detectors. Takes
// WIDTH-bit words over a valid/ready handshake and emits them one bit per
// clock on x. A one-word holding register lets the next word follow the
// current one with no idle bit. While idle, x is 0 so a downstream detector
// stays in its reset state.
// Parameters:
//   WIDTH     bits per word (2..32)
//   MSB_FIRST 1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   s         stream bundle (din/din_valid/din_ready in, x/x_valid/last/busy out)
//   state_dbg current FSM state (0 = IDLE, 1 = SHIFT) for checkers
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  seq_bit_serializer_if.slave s,
  output logic                state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] hold, hold_d;
  logic             hold_full, hold_full_d;

  logic             accept;
  logic [WIDTH-1:0] sh_shifted;
  logic             out_bit;

  // din_ready is forced low during reset so nothing is accepted in a cycle
  // whose state update is being discarded anyway.
  assign s.din_ready = !rst && !hold_full;
  assign accept      = s.din_valid && s.din_ready;

  // The output end is the bit that goes out next; the fill side takes zeros.
  always_comb begin
    if (MSB_FIRST != 0) begin
      sh_shifted = {sh[WIDTH-2:0], 1'b0};
      out_bit    = sh[WIDTH-1];
    end else begin
      sh_shifted = {1'b0, sh[WIDTH-1:1]};
      out_bit    = sh[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_d;
      sh        <= sh_d;
      cnt       <= cnt_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state;
    sh_d        = sh;
    cnt_d       = cnt;
    hold_d      = hold;
    hold_full_d = hold_full;

    unique case (state)
      IDLE: begin
        if (accept) begin
          sh_d    = s.din;
          cnt_d   = CNT_MAX;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt != '0) begin
          sh_d  = sh_shifted;
          cnt_d = cnt - 1'b1;
          // Park the next word; it is loaded when the current one finishes.
          if (accept) begin
            hold_d      = s.din;
            hold_full_d = 1'b1;
          end
        end else begin
          // Final bit of the word is on x: reload without a gap if possible.
          // din_ready is low here whenever hold_full is set, so the held word
          // and a fresh accept never compete.
          if (hold_full) begin
            sh_d        = hold;
            cnt_d       = CNT_MAX;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sh_d  = s.din;
            cnt_d = CNT_MAX;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign s.x       = (state == SHIFT) ? out_bit : 1'b0;
  assign s.x_valid = (state == SHIFT);
  assign s.last    = (state == SHIFT) && (cnt == '0);
  assign s.busy    = (state == SHIFT) || hold_full;
  assign state_dbg = (state == SHIFT);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
// Drives an MSB-first and an LSB-first 8-bit serializer with the same word
// stream. A bit-queue reference model predicts every output each cycle; a
// vector table and hand-written sequences pin down the documented timing.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din       = '0;
  logic         st_m, st_l;

  seq_bit_serializer_if #(.WIDTH(W)) if_m ();
  seq_bit_serializer_if #(.WIDTH(W)) if_l ();

  assign if_m.din       = din;
  assign if_m.din_valid = din_valid;
  assign if_l.din       = din;
  assign if_l.din_valid = din_valid;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .s(if_m), .state_dbg(st_m)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .s(if_l), .state_dbg(st_l)
  );

  // ---------------- scoreboard ----------------
  // Each entry is one bit still to appear on x: {is_last, lsb_first_bit, msb_first_bit}.
  // Entries beyond the first W belong to the word waiting in the holding register.
  logic [2:0] exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  logic s_xm, s_xl, s_xv, s_last, s_rdy, s_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model, advance the model, then let the rising edge happen.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    logic       e_rdy;
    logic [2:0] e;
    @(negedge clk);
    rst       = r;
    din_valid = v;
    din       = d;
    #1;
    s_xm   = if_m.x;
    s_xl   = if_l.x;
    s_xv   = if_m.x_valid;
    s_last = if_m.last;
    s_rdy  = if_m.din_ready;
    s_busy = if_m.busy;

    e_rdy = !r && (exp_q.size() <= W);
    e     = (exp_q.size() > 0) ? exp_q[0] : 3'b000;

    chk("x_msb",     32'(if_m.x),         32'(e[0]));
    chk("x_lsb",     32'(if_l.x),         32'(e[1]));
    chk("x_valid_m", 32'(if_m.x_valid),   32'(exp_q.size() > 0));
    chk("x_valid_l", 32'(if_l.x_valid),   32'(exp_q.size() > 0));
    chk("last_m",    32'(if_m.last),      32'(e[2]));
    chk("last_l",    32'(if_l.last),      32'(e[2]));
    chk("ready_m",   32'(if_m.din_ready), 32'(e_rdy));
    chk("ready_l",   32'(if_l.din_ready), 32'(e_rdy));
    chk("busy_m",    32'(if_m.busy),      32'(exp_q.size() > 0));
    chk("busy_l",    32'(if_l.busy),      32'(exp_q.size() > 0));
    chk("state_m",   32'(st_m),           32'(exp_q.size() > 0));

    if (r) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (v && e_rdy)
        for (int i = 0; i < W; i++)
          exp_q.push_back({(i == W - 1), d[i], d[W-1-i]});
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         x, xv, lst, rdy, bsy;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic v, logic [W-1:0] d, logic x, logic xv,
                              logic lst, logic rdy, logic bsy);
    vec_t t;
    t.v = v; t.d = d; t.x = x; t.xv = xv; t.lst = lst; t.rdy = rdy; t.bsy = bsy;
    return t;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] got_m, got_l, lp;
    int run;

    // 8'hA5 then 8'h3C back to back; din_valid stays high with junk while stalled.
    tbl[0]  = mk(1, 8'hA5, 0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 8'h3C, 1, 1, 0, 1, 1);
    tbl[2]  = mk(1, 8'hFF, 0, 1, 0, 0, 1);
    tbl[3]  = mk(1, 8'hFF, 1, 1, 0, 0, 1);
    tbl[4]  = mk(1, 8'hFF, 0, 1, 0, 0, 1);
    tbl[5]  = mk(1, 8'hFF, 0, 1, 0, 0, 1);
    tbl[6]  = mk(1, 8'hFF, 1, 1, 0, 0, 1);
    tbl[7]  = mk(1, 8'hFF, 0, 1, 0, 0, 1);
    tbl[8]  = mk(1, 8'hFF, 1, 1, 1, 0, 1);
    tbl[9]  = mk(0, 8'h00, 0, 1, 0, 1, 1);
    tbl[10] = mk(0, 8'h00, 0, 1, 0, 1, 1);
    tbl[11] = mk(0, 8'h00, 1, 1, 0, 1, 1);
    tbl[12] = mk(0, 8'h00, 1, 1, 0, 1, 1);
    tbl[13] = mk(0, 8'h00, 1, 1, 0, 1, 1);
    tbl[14] = mk(0, 8'h00, 1, 1, 0, 1, 1);
    tbl[15] = mk(0, 8'h00, 0, 1, 0, 1, 1);
    tbl[16] = mk(0, 8'h00, 0, 1, 1, 1, 1);
    tbl[17] = mk(0, 8'h00, 0, 0, 0, 1, 0);

    // Power-up reset: outputs are unknown until the first sampled reset edge.
    repeat (3) @(posedge clk);
    step(1, 0, '0);

    // Idle after reset: everything low, ready high.
    for (int i = 0; i < 10; i++) begin
      step(0, 0, W'($urandom));
      chk("idle_x",     32'(s_xm),   32'd0);
      chk("idle_ready", 32'(s_rdy),  32'd1);
      chk("idle_busy",  32'(s_busy), 32'd0);
    end

    // Table: A5 / 3C back-to-back, MSB-first view.
    for (int i = 0; i < 18; i++) begin
      step(0, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_x", i),     32'(s_xm),   32'(tbl[i].x));
      chk($sformatf("tbl%0d_xv", i),    32'(s_xv),   32'(tbl[i].xv));
      chk($sformatf("tbl%0d_last", i),  32'(s_last), 32'(tbl[i].lst));
      chk($sformatf("tbl%0d_ready", i), 32'(s_rdy),  32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_busy", i),  32'(s_busy), 32'(tbl[i].bsy));
    end
    step(0, 0, '0);

    // 8'b11010100 MSB-first, with last only on the eighth bit.
    step(0, 1, 8'b11010100);
    got_m = '0; lp = '0;
    for (int i = 0; i < W; i++) begin
      step(0, 0, '0);
      got_m = {got_m[W-2:0], s_xm};
      lp    = {lp[W-2:0], s_last};
    end
    chk("d4_msb_bits", 32'(got_m), 32'h0000_00D4);
    chk("d4_last_pos", 32'(lp),    32'h0000_0001);
    step(0, 0, '0);

    // 8'b00000011 LSB-first: x = 1,1,0,0,0,0,0,0.
    step(0, 1, 8'b00000011);
    got_l = '0;
    for (int i = 0; i < W; i++) begin
      step(0, 0, '0);
      got_l = {got_l[W-2:0], s_xl};
    end
    chk("03_lsb_bits", 32'(got_l), 32'h0000_00C0);
    step(0, 0, '0);

    // Reset mid-word with the holding register full.
    step(0, 1, 8'hA5);                 // N
    step(0, 1, 8'h3C);                 // N+1
    step(0, 0, '0);                    // N+2
    step(0, 0, '0);                    // N+3
    step(1, 0, '0);                    // N+4: rst high
    chk("rst_ready_low", 32'(s_rdy), 32'd0);
    step(1, 1, 8'h77);                 // N+5
    chk("rst_x",     32'(s_xm),   32'd0);
    chk("rst_xv",    32'(s_xv),   32'd0);
    chk("rst_busy",  32'(s_busy), 32'd0);
    chk("rst_ready", 32'(s_rdy),  32'd0);
    step(0, 0, '0);                    // released
    chk("rst_rel_ready", 32'(s_rdy), 32'd1);
    run = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, '0);
      run += int'(s_xv);
    end
    chk("rst_no_bits", 32'(run), 32'd0);

    // New word accepted exactly in the last cycle, holding register empty.
    step(0, 1, 8'h5A);                 // N
    run = 0;
    for (int i = 1; i < W; i++) begin  // N+1..N+7
      step(0, 0, '0);
      run += int'(s_xv);
    end
    step(0, 1, 8'hC3);                 // N+8: last bit of 5A
    run += int'(s_xv);
    chk("lc_last",  32'(s_last), 32'd1);
    chk("lc_ready", 32'(s_rdy),  32'd1);
    step(0, 0, '0);                    // N+9: first bit of C3
    run += int'(s_xv);
    chk("lc_first_bit", 32'(s_xm), 32'd1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, '0);
      run += int'(s_xv);
    end
    chk("lc_run_len", 32'(run), 32'(2 * W));

    // Randomized traffic, occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), W'($urandom));
    end

    // Drain.
    for (int i = 0; i < 2 * W + 2; i++) step(0, 0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
